rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump_pkg.sv | 17 +
 rtl/rf_dump.sv | 110 +++++++++++
 tb/tb_rf_dump.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared definitions for the register-file dump engine: register-file
// geometry and the dump controller state encoding.
package rf_dump_pkg;

  localparam int REG_AW  = 5;   // register index width
  localparam int REG_DW  = 32;  // register data width
  localparam int REG_NUM = 32;  // number of architectural registers

  // Dump controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage : rf_dump_pkg

// File: rtl/rf_dump.sv
// Register-file dump engine. Walks a spare asynchronous read port from the
// first to the last index, snapshots each register into an output holding
// register and offers it on a valid/ready stream. Never writes the file.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int LAST_ADDR = 31,  // highest index dumped (0..31)
  parameter int SKIP_ZERO = 0    // 1: begin the scan at index 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [REG_AW-1:0] ra,
  input  logic [REG_DW-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_addr,
  output logic [REG_DW-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_ADDR);
  localparam logic [REG_AW-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? REG_AW'(1) : REG_AW'(0);
  // With the first index past the last one there is nothing to send.
  localparam bit EMPTY_SCAN = ((SKIP_ZERO != 0) ? 1 : 0) > LAST_ADDR;

  state_e              state_q;
  logic [REG_AW-1:0]   idx_q;
  logic [REG_AW-1:0]   idx_d;
  logic                out_valid_q;
  logic [REG_AW-1:0]   out_addr_q;
  logic [REG_DW-1:0]   out_data_q;
  logic                done_q;

  // Next scan index; only ever used when idx_q is below LAST_IDX, so no wrap.
  assign idx_d = idx_q + REG_AW'(1);

  // Controller FSM with registered stream outputs and done pulse.
  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless the FIN entry below sets it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (EMPTY_SCAN) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= FIRST_IDX;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            // Snapshot the word now; later writes to this register are not seen.
            out_data_q  <= rd;
            out_addr_q  <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a handshake in the same cycle.
          if (abort) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              state_q <= READ;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ra        = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule : rf_dump

// File: tb/tb_rf_dump.sv
// Bench for rf_dump: three instances (full scan, SKIP_ZERO=1/LAST_ADDR=3,
// and an empty scan) share stimulus; one is observed at a time through a mux.
// Expected words come from a queue snapshot of the bench-owned register file.
module tb_rf_dump;
  import rf_dump_pkg::*;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  always #5 clk = ~clk;

  logic [REG_DW-1:0] rf [REG_NUM];

  logic [REG_AW-1:0] ra_a, ra_b, ra_c, oa_a, oa_b, oa_c;
  logic [REG_DW-1:0] rd_a, rd_b, rd_c, od_a, od_b, od_c;
  logic ov_a, ov_b, ov_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

  always_comb rd_a = rf[ra_a];
  always_comb rd_b = rf[ra_b];
  always_comb rd_c = rf[ra_c];

  rf_dump u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ra(ra_a), .rd(rd_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_addr(oa_a), .out_data(od_a),
    .busy(busy_a), .done(done_a));

  rf_dump #(.LAST_ADDR(3), .SKIP_ZERO(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ra(ra_b), .rd(rd_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_addr(oa_b), .out_data(od_b),
    .busy(busy_b), .done(done_b));

  rf_dump #(.LAST_ADDR(0), .SKIP_ZERO(1)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ra(ra_c), .rd(rd_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_addr(oa_c), .out_data(od_c),
    .busy(busy_c), .done(done_c));

  int sel = 0;
  logic m_valid, m_busy, m_done;
  logic [REG_AW-1:0] m_addr, m_ra;
  logic [REG_DW-1:0] m_data;

  always_comb begin
    m_valid = ov_a; m_busy = busy_a; m_done = done_a;
    m_addr  = oa_a; m_ra   = ra_a;   m_data = od_a;
    case (sel)
      1: begin
        m_valid = ov_b; m_busy = busy_b; m_done = done_b;
        m_addr  = oa_b; m_ra   = ra_b;   m_data = od_b;
      end
      2: begin
        m_valid = ov_c; m_busy = busy_c; m_done = done_c;
        m_addr  = oa_c; m_ra   = ra_c;   m_data = od_c;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_of(input int s);
    return (s == 0) ? 0 : 1;
  endfunction

  function automatic int last_of(input int s);
    return (s == 0) ? 31 : (s == 1) ? 3 : 0;
  endfunction

  task automatic load_rf();
    for (int i = 0; i < REG_NUM; i++) rf[i] = 32'(i) * 32'h1111_1111;
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check(tag, {19'd0, m_valid, m_busy, m_done, m_addr, m_ra, m_data}, 64'd0);
    end
    sel = 0;
  endtask

  task automatic gap();
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // One complete dump on instance s, called at a falling edge.
  // rand_ready: random out_ready; abort_addr/write_trig: -1 disables.
  task automatic run_dump(input int s, input bit rand_ready, input int abort_addr,
                          input int write_trig, input bit stray_start);
    logic [REG_DW-1:0] exp_q[$];
    logic [REG_AW-1:0] prev_addr;
    logic [REG_DW-1:0] prev_data;
    int first, last, n, last_hs;
    bit first_seen, prev_stall, finished, written;

    sel = s;
    first = first_of(s);
    last = last_of(s);
    exp_q = {};
    for (int a = first; a <= last; a++) exp_q.push_back(rf[a]);
    // A write made before word 5 is read must show up in word 5.
    if (write_trig >= 0 && write_trig < 5) exp_q[5 - first] = 32'hDEAD_BEEF;

    n = 0; last_hs = 0; first_seen = 0; prev_stall = 0; finished = 0; written = 0;
    prev_addr = '0; prev_data = '0;
    start = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (stray_start && c == 9) start = 1'b1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

      if (m_valid && !first_seen) begin
        first_seen = 1;
        check("first_valid_latency", 64'(c), 64'd1);
      end
      if (prev_stall) begin
        check("stall_valid", {63'd0, m_valid}, 64'd1);
        check("stall_addr", 64'(m_addr), 64'(prev_addr));
        check("stall_data", 64'(m_data), 64'(prev_data));
      end
      prev_stall = 0;

      if (m_done) begin
        check("done_after_last_hs", 64'(c), 64'(last_hs));
        check("word_count", 64'(n), 64'(exp_q.size()));
        check("valid_low_at_done", {63'd0, m_valid}, 64'd0);
        check("busy_in_fin", {63'd0, m_busy}, 64'd1);
        if (!rand_ready)
          check("total_cycles", 64'(last_hs), 64'(2 * exp_q.size()));
        @(negedge clk);
        check("done_one_cycle", {63'd0, m_done}, 64'd0);
        check("idle_after_fin", {63'd0, m_busy}, 64'd0);
        finished = 1;
        break;
      end

      check("busy_during_dump", {63'd0, m_busy}, 64'd1);

      if (m_valid && abort_addr >= 0 && int'(m_addr) == abort_addr) begin
        abort = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {63'd0, m_valid}, 64'd0);
        check("abort_busy", {63'd0, m_busy}, 64'd0);
        check("abort_words", 64'(n), 64'(abort_addr - first));
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", {63'd0, m_done}, 64'd0);
        end
        finished = 1;
        break;
      end

      if (m_valid) begin
        if (write_trig >= 0 && int'(m_addr) == write_trig && !written) begin
          rf[5] = 32'hDEAD_BEEF;
          written = 1;
        end
        check("ra_tracks_idx", 64'(m_ra), 64'(m_addr));
        if (out_ready) begin
          if (n >= exp_q.size()) begin
            check("extra_word", 64'(n), 64'(exp_q.size()));
          end else begin
            check("word_addr", 64'(m_addr), 64'(first + n));
            check("word_data", 64'(m_data), 64'(exp_q[n]));
          end
          n++;
          if (n == exp_q.size()) last_hs = c + 1;
        end else begin
          prev_stall = 1;
          prev_addr = m_addr;
          prev_data = m_data;
        end
      end
    end
    if (!finished) check("dump_terminated", 64'd0, 64'd1);
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    load_rf();
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("quiet_after_reset");

    // Full dump with ready held high, plus an ignored start while busy.
    gap();
    run_dump(0, 1'b0, -1, -1, 1'b1);

    // Random back-pressure.
    gap();
    run_dump(0, 1'b1, -1, -1, 1'b0);
    gap();
    run_dump(0, 1'b1, -1, -1, 1'b1);

    // Snapshot: write x5 during SEND of addr 5 (old value), then of addr 4 (new).
    gap();
    run_dump(0, 1'b0, -1, 5, 1'b0);
    load_rf();
    gap();
    run_dump(0, 1'b0, -1, 4, 1'b0);
    load_rf();

    // Abort at addr 10, then restart from addr 0.
    gap();
    run_dump(0, 1'b0, 10, -1, 1'b0);
    gap();
    run_dump(0, 1'b0, -1, -1, 1'b0);

    // Partial scans and the empty scan.
    gap();
    run_dump(1, 1'b0, -1, -1, 1'b0);
    gap();
    run_dump(1, 1'b1, -1, -1, 1'b0);
    gap();
    run_dump(2, 1'b0, -1, -1, 1'b0);

    // Asynchronous reset mid-dump, between clock edges.
    gap();
    sel = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset_mid_dump");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("quiet_after_mid_reset");
    gap();
    run_dump(0, 1'b1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rf_dump
